// File: rtl/gnn_0_example_rd_arbiter.sv
// Round-robin arbiter sharing one DRAM AXI read-master channel between the
// bias (0), weight (1) and feature (2) loaders. One transfer at a time: latch
// the winner's request, pulse read_start, then steer the returned beat stream
// to the granted requester until all beats and read_done have been seen.
module gnn_0_example_rd_arbiter #(
    parameter int NUM_REQ            = 3,
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int C_XFER_SIZE_WIDTH  = 32
) (
    input  logic                                  kernel_clk,
    input  logic                                  kernel_rst_n,
    input  logic [NUM_REQ-1:0]                    req_valid,
    input  logic [NUM_REQ*C_M_AXI_ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*C_XFER_SIZE_WIDTH-1:0]  req_size,
    output logic [NUM_REQ-1:0]                    req_ready,
    output logic [NUM_REQ-1:0]                    req_done,
    output logic [NUM_REQ-1:0]                    out_tvalid,
    input  logic [NUM_REQ-1:0]                    out_tready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]         out_tdata,
    output logic                                  out_tlast,
    output logic                                  busy,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]         dram_xfer_start_addr,
    output logic [C_XFER_SIZE_WIDTH-1:0]          dram_xfer_size_in_bytes,
    output logic                                  read_start,
    input  logic                                  read_done,
    input  logic                                  data_tvalid,
    output logic                                  data_tready,
    input  logic                                  data_tlast,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]         data_tdata
);
    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int XW = C_XFER_SIZE_WIDTH;
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // One extra bit so (size + 63) cannot wrap for sizes near the maximum
    localparam int CW = XW + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_XFER, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [XW-1:0]     size_q, size_d;
    logic [CW-1:0]     beats_q, beats_d;
    logic              seen_q, seen_d;

    logic              win_found;
    logic [PW-1:0]     win_idx;
    logic [XW-1:0]     win_size;
    logic [CW-1:0]     beats_exp;

    assign beats_exp               = ({1'b0, size_q} + CW'(63)) >> 6;
    assign win_size                = req_size[win_idx*XW +: XW];
    assign dram_xfer_start_addr    = addr_q;
    assign dram_xfer_size_in_bytes = size_q;
    assign busy                    = (state_q != S_IDLE);
    assign out_tdata               = data_tdata;
    assign out_tlast               = data_tlast;

    // Winner: first valid requester searching upward from ptr, wrapping
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = PW'(idx);
            end
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        ptr_d       = ptr_q;
        addr_d      = addr_q;
        size_d      = size_q;
        beats_d     = beats_q;
        seen_d      = seen_q;
        req_ready   = '0;
        req_done    = '0;
        read_start  = 1'b0;
        data_tready = 1'b0;
        out_tvalid  = '0;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    gnt_d   = NUM_REQ'(1) << win_idx;
                    ptr_d   = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + PW'(1);
                    addr_d  = req_addr[win_idx*AW +: AW];
                    size_d  = win_size;
                    // Zero-byte requests skip the read master entirely
                    state_d = (win_size == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                read_start = 1'b1;
                req_ready  = gnt_q;
                state_d    = S_XFER;
            end
            S_XFER: begin
                data_tready = |(out_tready & gnt_q);
                out_tvalid  = gnt_q & {NUM_REQ{data_tvalid}};
                beats_d     = beats_q + CW'(data_tvalid & data_tready);
                seen_d      = seen_q | read_done;
                // Use next-cycle values so a final beat and read_done in the
                // same cycle still finish on that edge
                if (seen_d && (beats_d == beats_exp)) state_d = S_DONE;
            end
            S_DONE: begin
                req_done = gnt_q;
                if (size_q == '0) req_ready = gnt_q;
                beats_d  = '0;
                seen_d   = 1'b0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, grant, pointer and transfer latches
    always_ff @(posedge kernel_clk or negedge kernel_rst_n) begin
        if (!kernel_rst_n) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            beats_q <= '0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            beats_q <= beats_d;
            seen_q  <= seen_d;
        end
    end
endmodule

// File: tb/tb_gnn_0_example_rd_arbiter.sv
// Bench for gnn_0_example_rd_arbiter: a table of directed transfers, a
// mid-transfer reset, a round-robin order check and randomized rounds, all
// checked against a round-robin / ceil(size/64) model kept here.
module tb_gnn_0_example_rd_arbiter;
    localparam int NR = 3;
    localparam int AW = 64;
    localparam int DW = 512;
    localparam int XW = 32;

    logic              kernel_clk = 1'b0;
    logic              kernel_rst_n = 1'b0;
    logic [NR-1:0]     req_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*XW-1:0]  req_size;
    logic [NR-1:0]     req_ready, req_done, out_tvalid;
    logic [NR-1:0]     out_tready = '0;
    logic [DW-1:0]     out_tdata;
    logic              out_tlast, busy, read_start, data_tready;
    logic [AW-1:0]     dram_xfer_start_addr;
    logic [XW-1:0]     dram_xfer_size_in_bytes;
    logic              read_done = 1'b0, data_tvalid = 1'b0, data_tlast = 1'b0;
    logic [DW-1:0]     data_tdata = '0;

    gnn_0_example_rd_arbiter dut (
        .kernel_clk(kernel_clk), .kernel_rst_n(kernel_rst_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_size(req_size),
        .req_ready(req_ready), .req_done(req_done),
        .out_tvalid(out_tvalid), .out_tready(out_tready),
        .out_tdata(out_tdata), .out_tlast(out_tlast), .busy(busy),
        .dram_xfer_start_addr(dram_xfer_start_addr),
        .dram_xfer_size_in_bytes(dram_xfer_size_in_bytes),
        .read_start(read_start), .read_done(read_done),
        .data_tvalid(data_tvalid), .data_tready(data_tready),
        .data_tlast(data_tlast), .data_tdata(data_tdata)
    );

    always #5 kernel_clk = ~kernel_clk;

    int total = 0;
    int bad   = 0;
    int m_ptr = 0;

    // Pending requests as seen by the requesters
    logic [AW-1:0] p_addr [NR];
    logic [XW-1:0] p_size [NR];
    logic [NR-1:0] pmask = '0;

    always_comb begin
        req_valid = pmask;
        req_addr  = '0;
        req_size  = '0;
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW] = p_addr[i];
            req_size[i*XW +: XW] = p_size[i];
        end
    end

    typedef struct {
        int          r;
        logic [63:0] addr;
        logic [31:0] size;
        int          mode;
        int          beats;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ready"}, req_ready, 0);
        chk({tag, "_done"}, req_done, 0);
        chk({tag, "_rstart"}, read_start, 0);
        chk({tag, "_tready"}, data_tready, 0);
        chk({tag, "_tvalid"}, out_tvalid, 0);
        chk({tag, "_addr"}, dram_xfer_start_addr, 0);
        chk({tag, "_size"}, dram_xfer_size_in_bytes, 0);
    endtask

    // Model: first pending requester at or after the pointer, wrapping
    function automatic int model_win(input logic [NR-1:0] m);
        for (int k = 0; k < NR; k++)
            if (m[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
        return 0;
    endfunction

    // One arbitration round, starting in an IDLE cycle at a negedge.
    // mode: 0 read_done with last beat, 1 read_done after last beat,
    //       2 read_done early (after first beat), 3 tready drop of 5 cycles,
    //       4 reset while beat 3 is pending.
    task automatic grant_round(input int mode, input bit keep, input int exp_n,
                               output int dut_w);
        int w, n, sent, drop, cyc;
        bit rdg;
        w = model_win(pmask);
        m_ptr = (w + 1) % NR;
        n = (exp_n >= 0) ? exp_n : (int'(p_size[w]) + 63) / 64;
        @(posedge kernel_clk);
        @(negedge kernel_clk);
        dut_w = -1;
        for (int i = 0; i < NR; i++) if (req_ready[i]) dut_w = i;
        chk("grant_ready", req_ready, 64'(1) << w);
        chk("grant_busy", busy, 1);
        if (p_size[w] == 0) begin
            chk("zero_rstart", read_start, 0);
            chk("zero_done", req_done, 64'(1) << w);
            if (!keep) pmask[w] = 1'b0;
            @(negedge kernel_clk);
            chk("zero_idle", busy, 0);
            return;
        end
        chk("issue_rstart", read_start, 1);
        chk("issue_done", req_done, 0);
        chk("issue_addr", dram_xfer_start_addr, p_addr[w]);
        chk("issue_size", dram_xfer_size_in_bytes, 64'(p_size[w]));
        if (!keep) pmask[w] = 1'b0;
        sent = 0; rdg = 0; drop = 0; cyc = 0;
        while (!(sent == n && rdg) && cyc < 500) begin
            @(negedge kernel_clk);
            cyc++;
            read_done  = 1'b0;
            data_tlast = (sent == n - 1);
            for (int k = 0; k < DW / 32; k++) data_tdata[k*32 +: 32] = $urandom;
            data_tvalid = (sent < n) && (mode == 3 || $urandom_range(0, 3) != 0);
            for (int i = 0; i < NR; i++) out_tready[i] = 1'($urandom_range(0, 1));
            out_tready[w] = (mode == 3) ? 1'b1 : ($urandom_range(0, 4) != 0);
            if (mode == 3 && sent == 3 && drop < 5) begin
                out_tready[w] = 1'b0;
                drop++;
            end
            if (mode == 4 && sent == 2) begin
                kernel_rst_n = 1'b0;
                data_tvalid  = 1'b0;
                #1;
                chk_reset_outputs("midrst");
                @(posedge kernel_clk);
                @(negedge kernel_clk);
                kernel_rst_n = 1'b1;
                m_ptr = 0;
                pmask = '0;
                return;
            end
            if (mode == 2 && sent == 1 && !rdg && n > 1) begin
                data_tvalid = 1'b0; read_done = 1'b1; rdg = 1;
            end else if (mode == 0 && data_tvalid && sent == n - 1 && !rdg) begin
                read_done = 1'b1; rdg = 1;
            end else if (sent == n && !rdg) begin
                read_done = 1'b1; rdg = 1;
            end
            #1;
            chk("xfer_tready", data_tready, out_tready[w]);
            chk("xfer_tvalid", out_tvalid, data_tvalid ? (64'(1) << w) : 64'(0));
            chk("xfer_tdata", out_tdata == data_tdata, 1);
            chk("xfer_tlast", out_tlast, data_tlast);
            chk("xfer_done", req_done, 0);
            chk("xfer_rstart", read_start, 0);
            chk("xfer_ready", req_ready, 0);
            if (data_tvalid && data_tready) sent++;
        end
        if (cyc >= 500) begin
            total++; bad++;
            $display("FAIL xfer_timeout: got %0d beats want %0d", sent, n);
        end
        @(negedge kernel_clk);
        read_done = 1'b0; data_tvalid = 1'b0; data_tlast = 1'b0;
        #1;
        chk("done_pulse", req_done, 64'(1) << w);
        chk("done_ready", req_ready, 0);
        chk("done_busy", busy, 1);
        chk("done_tready", data_tready, 0);
        chk("done_tvalid", out_tvalid, 0);
        @(negedge kernel_clk);
        chk("idle_busy", busy, 0);
        chk("idle_done", req_done, 0);
    endtask

    initial begin
        vec_t tbl [6];
        int   w;
        int   rr_order [6];
        for (int i = 0; i < NR; i++) begin p_addr[i] = '0; p_size[i] = '0; end
        tbl[0] = '{0, 64'h0,    32'd128,  1, 2};
        tbl[1] = '{1, 64'h1000, 32'd100,  2, 2};
        tbl[2] = '{1, 64'h2000, 32'd1024, 3, 16};
        tbl[3] = '{2, 64'h3000, 32'd0,    0, 0};
        tbl[4] = '{2, 64'h40,   32'd64,   0, 1};
        tbl[5] = '{0, 64'h5000, 32'd65,   0, 2};
        rr_order = '{0, 1, 2, 0, 1, 2};

        repeat (3) @(negedge kernel_clk);
        chk_reset_outputs("reset");
        kernel_rst_n = 1'b1;
        @(negedge kernel_clk);

        // Directed table, one requester at a time
        foreach (tbl[t]) begin
            p_addr[tbl[t].r] = tbl[t].addr;
            p_size[tbl[t].r] = tbl[t].size;
            pmask = NR'(1) << tbl[t].r;
            grant_round(tbl[t].mode, 1'b0, tbl[t].beats, w);
        end

        // Reset during beat 3 of 16, then requester 0 must win first
        p_addr[1] = 64'h8000; p_size[1] = 32'd1024; pmask = 3'b010;
        grant_round(4, 1'b0, -1, w);
        for (int i = 0; i < NR; i++) begin p_addr[i] = 64'h100 * (i + 1); p_size[i] = 32'd64; end
        pmask = 3'b111;
        for (int k = 0; k < 6; k++) begin
            grant_round(0, 1'b1, -1, w);
            chk("rr_order", 64'(w), 64'(rr_order[k]));
        end
        pmask = '0;

        // Randomized rounds
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < NR; i++) begin
                if (!pmask[i] && $urandom_range(0, 1) == 1) begin
                    p_addr[i] = {$urandom, $urandom};
                    p_size[i] = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 600));
                    pmask[i]  = 1'b1;
                end
            end
            if (pmask == '0) begin
                p_addr[0] = 64'hA000; p_size[0] = 32'd200; pmask[0] = 1'b1;
            end
            grant_round($urandom_range(0, 2), 1'b0, -1, w);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
